gray_code_conv: RTL and testbench
=================================

Name: gray_code_conv

Overview:
Binary-to-Gray converter. A reverse Gray-to-binary mode is selectable. The zero-latency combinational output is kept for existing users that instantiate the block with only output and input (positional order OUT, IN). A registered copy of the output with a valid flag is provided for pipelined datapaths (counter/FIFO pointer encoding, CDC pointer synchronisation).

Parameters:
- WIDTH, 4, data width in bits of IN, OUT and OUT_Q; legal range ≥ 1.

Ports:
- CLK  input  1  clock; all registers update on its rising edge.
- RST_N  input  1  asynchronous active-low reset; release is synchronous to CLK.
- OUT  output  WIDTH  combinational conversion of IN.
- IN  input  WIDTH  data to convert.
- MODE  input  1  0 = binary→Gray (default use); 1 = Gray→binary.
- IN_VALID  input  1  qualifies IN for the registered path.
- OUT_Q  output  WIDTH  registered conversion result.
- OUT_VALID  output  1  OUT_Q holds a fresh result.

Port order at instantiation:
- OUT, IN first, so the legacy two-port positional hookup works.
- Then CLK, RST_N, MODE, IN_VALID, OUT_Q, OUT_VALID.
- When left unconnected, MODE and IN_VALID are tied low in the wrapper sense. Integrators tie MODE=0 for the legacy use.

Behaviour:
- Binary→Gray (MODE=0):
  - OUT[WIDTH-1] = IN[WIDTH-1].
  - OUT[i] = IN[i+1] XOR IN[i] for i = WIDTH-2..0.
- Gray→binary (MODE=1):
  - OUT[WIDTH-1] = IN[WIDTH-1].
  - OUT[i] = OUT[i+1] XOR IN[i], i.e. prefix XOR from the MSB down.
- OUT timing and reset:
  - OUT is purely combinational, zero latency.
  - OUT is independent of CLK and RST_N, and tracks IN/MODE changes within one delta.
  - X/Z on any IN bit propagates to the dependent OUT bits only.
- Registered path:
  - On a CLK rising edge with IN_VALID=1: OUT_Q ← conversion of IN under the current MODE, and OUT_VALID ← 1.
  - On a CLK rising edge with IN_VALID=0: OUT_Q holds its value and OUT_VALID ← 0.
  - Latency is one cycle; throughput is one conversion per cycle; no backpressure.
- Reset:
  - RST_N low forces OUT_Q = 0 and OUT_VALID = 0 immediately, with no clock edge required.
  - Reset asserted mid-stream discards the in-flight result.
  - The first capture happens on the first rising edge after RST_N is high with IN_VALID=1.
- Mode switching: MODE may change on any cycle. The registered result uses the MODE value sampled on the same edge as IN.
- Width boundaries:
  - WIDTH=1: OUT = IN in both modes.
  - All-zero input maps to all-zero output in both modes.
  - The modes are mutual inverses: Gray→binary(binary→Gray(x)) = x for every x.
- Gray property: for a binary input x, the outputs for x and x+1 (mod 2^WIDTH) differ in exactly one bit. This includes the wrap from all-ones to zero.

Test Plan:
- Exhaustive sweep, MODE=0, WIDTH=4, IN stepping 0000→1111 at 1 ns intervals → OUT equals 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
- Spot checks, MODE=0 → IN=0101 gives OUT=0111; IN=1011 gives OUT=1110; IN=1000 gives OUT=1100.
- Gray→binary, MODE=1 → IN=1011 gives OUT=1101; IN=1000 gives OUT=1111; round trip of all 16 codes through both modes returns the original value.
- Registered path → with IN=0101, MODE=0, IN_VALID=1, the first CLK edge after reset release gives OUT_Q=0111 and OUT_VALID=1; on the next edge with IN_VALID=0, OUT_Q stays 0111 and OUT_VALID=0.
- Async reset → assert RST_N low between clock edges while OUT_Q=1000 and OUT_VALID=1; both clear to 0 immediately, while OUT keeps following IN.
- Adjacency check → for x = 0..15, popcount(OUT(x) XOR OUT(x+1 mod 16)) = 1; repeat at WIDTH=8 for all 256 values.

Source files
------------

// File: rtl/gray_code_conv.sv
// rtl/gray_code_conv.sv - binary/Gray converter with combinational output and registered, valid-qualified copy
module gray_code_conv #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] OUT,
    input  logic [WIDTH-1:0] IN,
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             MODE,
    input  logic             IN_VALID,
    output logic [WIDTH-1:0] OUT_Q,
    output logic             OUT_VALID
);

    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;

    assign gray = IN ^ (IN >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it, so an X only
    // reaches the bits it actually feeds.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bin
        assign bin[i] = ^(IN >> i);
    end

    assign OUT = MODE ? bin : gray;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_Q     <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID) begin
                OUT_Q <= OUT;
            end
        end
    end

endmodule

// File: tb/tb_gray_code_conv.sv
// tb/tb_gray_code_conv.sv - self-checking bench for gray_code_conv
module tb_gray_code_conv;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in4, out4, outq4;
    logic       mode4, iv4, ov4;
    logic [7:0] in8, out8, outq8;
    logic       mode8, iv8, ov8;

    always #5 clk = ~clk;

    gray_code_conv #(.WIDTH(4)) dut4 (
        .OUT(out4), .IN(in4), .CLK(clk), .RST_N(rst_n), .MODE(mode4),
        .IN_VALID(iv4), .OUT_Q(outq4), .OUT_VALID(ov4)
    );

    gray_code_conv #(.WIDTH(8)) dut8 (
        .OUT(out8), .IN(in8), .CLK(clk), .RST_N(rst_n), .MODE(mode8),
        .IN_VALID(iv8), .OUT_Q(outq8), .OUT_VALID(ov8)
    );

    typedef struct {
        logic [3:0] in;
        logic       mode;
        logic [3:0] exp;
    } vec_t;

    int checks = 0;
    int fails  = 0;

    // Reference Gray sequence built by reflect-and-prefix; its 4-bit code is
    // the first 16 entries of the 8-bit one.
    int gseq[256];
    int ginv[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic build_model();
        int len;
        gseq[0] = 0;
        len = 1;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < len; j++)
                gseq[len + j] = gseq[len - 1 - j] | (1 << k);
            len = len * 2;
        end
        for (int x = 0; x < 256; x++)
            ginv[gseq[x]] = x;
    endtask

    function automatic logic [3:0] model4(input logic [3:0] v, input logic m);
        return m ? 4'(ginv[int'(v)]) : 4'(gseq[int'(v)]);
    endfunction

    initial begin
        vec_t       vecs[$];
        int         sweep_exp[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
        logic [3:0] a4, b4, exp_q;
        logic [7:0] a8, b8;
        logic       exp_v;

        build_model();
        for (int x = 0; x < 16; x++)
            vecs.push_back('{in: 4'(x), mode: 1'b0, exp: 4'(sweep_exp[x])});
        vecs.push_back('{in: 4'b0101, mode: 1'b0, exp: 4'b0111});
        vecs.push_back('{in: 4'b1011, mode: 1'b0, exp: 4'b1110});
        vecs.push_back('{in: 4'b1000, mode: 1'b0, exp: 4'b1100});
        vecs.push_back('{in: 4'b1011, mode: 1'b1, exp: 4'b1101});
        vecs.push_back('{in: 4'b1000, mode: 1'b1, exp: 4'b1111});
        vecs.push_back('{in: 4'b0000, mode: 1'b1, exp: 4'b0000});

        rst_n = 1'b0;
        in4 = '0; mode4 = 1'b0; iv4 = 1'b0;
        in8 = '0; mode8 = 1'b0; iv8 = 1'b0;
        #1;
        check("reset_out_q", 32'(outq4), 32'h0);
        check("reset_out_valid", 32'(ov4), 32'h0);

        // Combinational table, applied while reset is held to show OUT ignores it
        foreach (vecs[i]) begin
            in4 = vecs[i].in; mode4 = vecs[i].mode;
            #1;
            check($sformatf("vec%0d", i), 32'(out4), 32'(vecs[i].exp));
        end

        for (int x = 0; x < 16; x++) begin
            mode4 = 1'b0; in4 = 4'(x);
            #1;
            a4 = out4;
            check("model_b2g", 32'(a4), 32'(gseq[x]));
            mode4 = 1'b1; in4 = a4;
            #1;
            check("round_trip", 32'(out4), 32'(x));
        end

        for (int i = 0; i < 200; i++) begin
            in4 = 4'($urandom_range(0, 15)); mode4 = 1'($urandom_range(0, 1));
            #1;
            check("rand_comb", 32'(out4), 32'(model4(in4, mode4)));
        end

        mode4 = 1'b0; mode8 = 1'b0;
        for (int x = 0; x < 16; x++) begin
            in4 = 4'(x); #1; a4 = out4;
            in4 = 4'(x + 1); #1; b4 = out4;
            check("adjacent4", 32'($countones(a4 ^ b4)), 32'd1);
        end
        for (int x = 0; x < 256; x++) begin
            in8 = 8'(x); #1; a8 = out8;
            check("model8", 32'(a8), 32'(gseq[x]));
            in8 = 8'(x + 1); #1; b8 = out8;
            check("adjacent8", 32'($countones(a8 ^ b8)), 32'd1);
        end
        mode8 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            in8 = 8'($urandom_range(0, 255)); #1;
            check("g2b8", 32'(out8), 32'(ginv[int'(in8)]));
        end

        // Registered path: first capture right after release
        @(negedge clk);
        rst_n = 1'b1; in4 = 4'b0101; mode4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        check("first_capture_q", 32'(outq4), 32'h7);
        check("first_capture_v", 32'(ov4), 32'h1);
        @(negedge clk);
        iv4 = 1'b0; in4 = 4'b1111;
        @(posedge clk); #1;
        check("hold_q", 32'(outq4), 32'h7);
        check("hold_v", 32'(ov4), 32'h0);
        @(negedge clk);
        iv4 = 1'b1;
        @(posedge clk); #1;
        check("cap_1000_q", 32'(outq4), 32'h8);
        check("cap_1000_v", 32'(ov4), 32'h1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0; in4 = 4'b0011;
        #1;
        check("async_rst_q", 32'(outq4), 32'h0);
        check("async_rst_v", 32'(ov4), 32'h0);
        check("out_during_rst", 32'(out4), 32'h2);
        @(posedge clk); #1;
        check("rst_held_q", 32'(outq4), 32'h0);
        check("rst_held_v", 32'(ov4), 32'h0);

        // Random pipelined stream with mode switching
        @(negedge clk);
        rst_n = 1'b1;
        exp_q = '0; exp_v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in4   = 4'($urandom_range(0, 15));
            mode4 = 1'($urandom_range(0, 1));
            iv4   = 1'($urandom_range(0, 3) != 0);
            @(posedge clk);
            exp_v = iv4;
            if (iv4) exp_q = model4(in4, mode4);
            #1;
            check("rand_q", 32'(outq4), 32'(exp_q));
            check("rand_v", 32'(ov4), 32'(exp_v));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
